// File: rtl/rtc_pkg.sv
// Shared types and constants for the RTC bus responder: FSM state encoding,
// default geometry and the watchdog limit.
package rtc_pkg;

  localparam int DATA_W_DFLT = 8;
  localparam int DEPTH_DFLT  = 16;
  localparam int WDOG_W      = 6;
  localparam int WDOG_MAX    = 63;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ADDR_PH = 3'd1,
    ST_ADDR_OK = 3'd2,
    ST_DATA_RD = 3'd3,
    ST_DATA_WR = 3'd4
  } state_e;

endpackage

// File: rtl/rtc_sync_edge.sv
// Multi-flop synchronizer for one active-low bus control line, with a
// rising-edge pulse derived from the synchronized value.
module rtc_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic s_o,
  output logic rise_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  // Idle level of every strobe is high, so flops reset to 1 to avoid a false edge.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '1;
      prev_q <= 1'b1;
    end else begin
      sync_q[0] <= d_i;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign s_o    = sync_q[SYNC_STAGES-1];
  assign rise_o = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/rtc_bus_responder.sv
// Responder for the multiplexed address/data RTC bus with a local register port.
// Optional build macro RTC_RESP_WATCHDOG_EN aborts transfers stuck for 63 cycles.
module rtc_bus_responder
  import rtc_pkg::*;
#(
  parameter  int DATA_W      = DATA_W_DFLT,
  parameter  int DEPTH       = DEPTH_DFLT,
  parameter  int SYNC_STAGES = 2,
  localparam int AW          = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ad_n,
  input  logic              cs_n,
  input  logic              rd_n,
  input  logic              wr_n,
  input  logic [DATA_W-1:0] bus_in,
  output logic [DATA_W-1:0] bus_out,
  output logic              bus_oe,
  input  logic              loc_we,
  input  logic [AW-1:0]     loc_addr,
  input  logic [DATA_W-1:0] loc_wdata,
  output logic [DATA_W-1:0] loc_rdata,
  output logic              wr_strobe,
  output logic              rd_strobe,
  output logic [AW-1:0]     acc_addr,
  output logic              proto_err
);

  logic ad_s, cs_s, rd_s, wr_s;
  logic cs_rise, rd_rise, wr_rise, ad_rise_unused;

  rtc_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_ad (
    .clk_i(clk), .rst_ni(reset), .d_i(ad_n), .s_o(ad_s), .rise_o(ad_rise_unused));
  rtc_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_cs (
    .clk_i(clk), .rst_ni(reset), .d_i(cs_n), .s_o(cs_s), .rise_o(cs_rise));
  rtc_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_rd (
    .clk_i(clk), .rst_ni(reset), .d_i(rd_n), .s_o(rd_s), .rise_o(rd_rise));
  rtc_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_wr (
    .clk_i(clk), .rst_ni(reset), .d_i(wr_n), .s_o(wr_s), .rise_o(wr_rise));

  // Data pipeline matches the strobe synchronizer depth so bus_d lines up with *_s.
  logic [DATA_W-1:0] bus_pipe_q [SYNC_STAGES];
  logic [DATA_W-1:0] bus_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        bus_pipe_q[i] <= '0;
      end
    end else begin
      bus_pipe_q[0] <= bus_in;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        bus_pipe_q[i] <= bus_pipe_q[i-1];
      end
    end
  end

  assign bus_d = bus_pipe_q[SYNC_STAGES-1];

  state_e            state_q, state_d;
  logic [AW-1:0]     acc_addr_q;
  logic              addr_oor_q;
  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [DATA_W-1:0] bus_out_q, loc_rdata_q;
  logic              bus_oe_q, wr_strobe_q, rd_strobe_q, proto_err_q;

  logic addr_latch, rd_start, rd_done, wr_commit, err_d, abort;
  logic loc_in_range;

  assign loc_in_range = (int'(loc_addr) < DEPTH);

`ifdef RTC_RESP_WATCHDOG_EN
  logic [WDOG_W-1:0] wdog_q, wdog_d;

  always_comb begin
    wdog_d = wdog_q + 1'b1;
    if (state_q == ST_IDLE || state_d != state_q) begin
      wdog_d = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wdog_q <= '0;
    end else begin
      wdog_q <= wdog_d;
    end
  end
`endif

  always_comb begin
    state_d    = state_q;
    addr_latch = 1'b0;
    rd_start   = 1'b0;
    rd_done    = 1'b0;
    wr_commit  = 1'b0;
    err_d      = 1'b0;
    abort      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!cs_s) begin
          if (ad_s) begin
            err_d = 1'b1;
          end else if (!wr_s) begin
            state_d = ST_ADDR_PH;
          end
        end
      end
      ST_ADDR_PH: begin
        if (!rd_s) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else if (wr_rise || cs_rise) begin
          addr_latch = 1'b1;
          state_d    = ST_ADDR_OK;
        end
      end
      ST_ADDR_OK: begin
        if (!rd_s && !wr_s) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else if (!cs_s) begin
          if (ad_s && !rd_s) begin
            rd_start = 1'b1;
            state_d  = ST_DATA_RD;
          end else if (ad_s && !wr_s) begin
            state_d = ST_DATA_WR;
          end else if (!ad_s && !wr_s) begin
            state_d = ST_ADDR_PH;
          end
        end
      end
      ST_DATA_RD: begin
        if (rd_rise || cs_rise) begin
          rd_done = 1'b1;
          err_d   = addr_oor_q;
          state_d = ST_IDLE;
        end
      end
      ST_DATA_WR: begin
        if (wr_rise || cs_rise) begin
          wr_commit = !addr_oor_q;
          err_d     = addr_oor_q;
          state_d   = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
`ifdef RTC_RESP_WATCHDOG_EN
    if (wdog_q == WDOG_W'(WDOG_MAX)) begin
      state_d    = ST_IDLE;
      addr_latch = 1'b0;
      rd_start   = 1'b0;
      rd_done    = 1'b0;
      wr_commit  = 1'b0;
      err_d      = 1'b1;
      abort      = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Bus write is applied after the local write so it wins on an address collision.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      if (loc_we && loc_in_range) begin
        regs_q[loc_addr] <= loc_wdata;
      end
      if (wr_commit) begin
        regs_q[acc_addr_q] <= bus_d;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_addr_q  <= '0;
      addr_oor_q  <= 1'b0;
      bus_out_q   <= '0;
      bus_oe_q    <= 1'b0;
      loc_rdata_q <= '0;
      wr_strobe_q <= 1'b0;
      rd_strobe_q <= 1'b0;
      proto_err_q <= 1'b0;
    end else begin
      wr_strobe_q <= wr_commit;
      rd_strobe_q <= rd_done;
      proto_err_q <= err_d;
      if (addr_latch) begin
        acc_addr_q <= bus_d[AW-1:0];
        addr_oor_q <= (int'(bus_d) >= DEPTH);
      end
      if (rd_start) begin
        bus_oe_q  <= 1'b1;
        bus_out_q <= addr_oor_q ? '0 : regs_q[acc_addr_q];
      end else if (rd_done || abort) begin
        bus_oe_q <= 1'b0;
      end
      loc_rdata_q <= loc_in_range ? regs_q[loc_addr] : '0;
    end
  end

  assign bus_out   = bus_out_q;
  assign bus_oe    = bus_oe_q;
  assign loc_rdata = loc_rdata_q;
  assign wr_strobe = wr_strobe_q;
  assign rd_strobe = rd_strobe_q;
  assign acc_addr  = acc_addr_q;
  assign proto_err = proto_err_q;

endmodule

// File: doc/rtc_bus_responder.md
Name: rtc_bus_responder

Overview:
- Responder end of the multiplexed address/data RTC bus: AD, CS, RD and WR are all active-low.
- Used two ways:
  - as a V3023-style register-file model for verification benches;
  - as an on-FPGA RTC emulator behind the transfer initiator.
- Decodes the address phase and the data phase, then serves reads from or commits writes to an internal register file.
- A local port lets the time-keeping logic read and update the registers.

Parameters:
- DATA_W, 8, width of the bus and of each register.
- DEPTH, 16, number of registers. Address width is AW = clog2(DEPTH).
- SYNC_STAGES, 2, number of synchronizer flops on every bus input.

Ports:
- clk  in  1  system clock, 100 MHz.
- reset  in  1  asynchronous, active-low reset.
- ad_n  in  1  address/data select: 0 = address phase, 1 = data phase.
- cs_n  in  1  chip select, active-low.
- rd_n  in  1  read strobe, active-low. Pulled up externally; the bench drives 1 where the initiator floats it.
- wr_n  in  1  write strobe, active-low.
- bus_in  in  DATA_W  bus value driven by the initiator.
- bus_out  out  DATA_W  read data.
- bus_oe  out  1  responder drives the bus.
- loc_we  in  1  local write enable.
- loc_addr  in  AW  local address.
- loc_wdata  in  DATA_W  local write data.
- loc_rdata  out  DATA_W  registered local read data, 1-cycle latency.
- wr_strobe  out  1  one-cycle pulse when a bus write commits.
- rd_strobe  out  1  one-cycle pulse when a bus read ends.
- acc_addr  out  AW  last latched bus address.
- proto_err  out  1  one-cycle pulse on any protocol violation.

Behaviour:
- Reset (asynchronous, active-low) forces:
  - FSM to IDLE;
  - synchronizer flops to 1 and bus_in pipeline flops to 0;
  - all registers to 0;
  - bus_oe=0, bus_out=0, loc_rdata=0;
  - all strobes and proto_err to 0, acc_addr=0.
  Reset asserted mid-transfer abandons the transfer; nothing is written.
- Input synchronization: ad_n, cs_n, rd_n and wr_n pass through SYNC_STAGES flops, giving the *_s signals. bus_in passes through an equal-depth pipeline, giving bus_d, so data stays aligned with the strobes. Rising edges are detected on the *_s signals.
- FSM states: IDLE, ADDR_PH, ADDR_OK, DATA_RD, DATA_WR.
  - IDLE:
    - cs_s=0, ad_s=0, wr_s=0 → ADDR_PH.
    - cs_s=0 with ad_s=1 → proto_err pulse; stay in IDLE.
  - ADDR_PH:
    - First rising edge of wr_s or cs_s → acc_addr <= bus_d[AW-1:0]; go to ADDR_OK.
    - rd_s=0 during this state → proto_err pulse; go to IDLE.
  - ADDR_OK:
    - cs_s=0, ad_s=1, rd_s=0 → DATA_RD. On the next cycle bus_oe=1 and bus_out=reg[acc_addr].
    - cs_s=0, ad_s=1, wr_s=0 → DATA_WR.
    - cs_s=0, ad_s=0, wr_s=0 → ADDR_PH (re-address).
    - rd_s=0 and wr_s=0 together → proto_err pulse; go to IDLE.
  - DATA_RD: rising edge of rd_s or cs_s → bus_oe=0 on the same clock edge, rd_strobe pulse, go to IDLE. bus_out holds its value until the next read.
  - DATA_WR: rising edge of wr_s or cs_s → reg[acc_addr] <= bus_d, wr_strobe pulse, go to IDLE.
- Out-of-range address (bus_d value >= DEPTH before truncation, or acc_addr >= DEPTH when DEPTH is not a power of two):
  - reads return 0;
  - writes are dropped;
  - proto_err pulses at data-phase end.
- Local port:
  - loc_we writes reg[loc_addr] on the clock edge.
  - loc_rdata = reg[loc_addr], registered.
  - A bus write and a local write to the same address on the same cycle: the bus write wins. Different addresses: both commit.
- Latency from the initiator's edge to the responder's reaction is SYNC_STAGES+1 cycles. The initiator's windows (≥6 cycles) absorb this.

Optional Feature:
- Macro: RTC_RESP_WATCHDOG_EN.
- With the macro defined:
  - A 6-bit counter runs in every state except IDLE and clears on each state change.
  - When it reaches 63, the FSM returns to IDLE, bus_oe drops to 0, proto_err pulses, and nothing is written.
- Without the macro: no counter exists, and the FSM waits indefinitely.

Decomposition:
- Shared package rtc_pkg holds:
  - the FSM state enum (3-bit encoding);
  - DATA_W and DEPTH defaults;
  - the watchdog limit constant WDOG_MAX=63.
- One sub-module, rtc_sync_edge: a SYNC_STAGES-deep synchronizer with a rising-edge output, instanced once per control input.

Test Plan:
- Write then read back: write address 0x05 with data 0xA7, then read address 0x05 → wr_strobe fires once, bus_out=0xA7 while bus_oe=1, rd_strobe fires once.
- Local/bus interaction:
  - loc_we writes 0x3C to address 0x02, then the bus reads address 0x02 → 0x3C.
  - Bus and local writes to address 0x07 on the same cycle, with bus data 0x11 and local data 0x22 → loc_rdata=0x11.
- Address 0x1F with DEPTH=16 (top bit truncated out of range): read → bus_out=0x00 and proto_err pulses; write → no register changes.
- Protocol violations:
  - rd_n low during the address phase → proto_err, FSM returns to IDLE, bus_oe stays 0.
  - rd_n and wr_n low together in the data phase → proto_err, no write.
- reset asserted mid DATA_RD → bus_oe=0 immediately (asynchronous), all registers read 0 afterwards.
- With RTC_RESP_WATCHDOG_EN defined: address phase completed, then 70 idle cycles with cs_n low → FSM back in IDLE at cycle 64, proto_err pulses.
